// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port synchronous RAM with byte enables, collision arbitration
// and post-reset clear FSM. Define DPRAM_OUT_REG_EN to add an output register stage (latency 2).
module dual_port_ram_param #(
    parameter int DATA_W           = 8,
    parameter int ADDR_W           = 6,
    parameter int RDW_MODE         = 0,
    parameter int COLLISION_WINNER = 0,
    parameter int CLEAR_ON_RESET   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_a,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   data_a,
    output logic [DATA_W-1:0]   q_a,
    output logic                rvalid_a,
    input  logic                en_b,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   data_b,
    output logic [DATA_W-1:0]   q_b,
    output logic                rvalid_b,
    output logic                busy,
    output logic                collision
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_a;
    logic                wr_b;
    logic                same_addr;
    logic                overlap;
    logic [DATA_W-1:0]   old_a;
    logic [DATA_W-1:0]   old_b;
    logic [DATA_W-1:0]   new_a;
    logic [DATA_W-1:0]   new_b;
    logic [DATA_W-1:0]   q1_a;
    logic [DATA_W-1:0]   q1_b;
    logic                rv1_a;
    logic                rv1_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (&cnt) state_next = IDLE;
            IDLE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state == CLEAR);
    assign wr_a      = en_a & we_a & ~busy;
    assign wr_b      = en_b & we_b & ~busy;
    assign same_addr = (addr_a == addr_b);
    assign overlap   = wr_a & wr_b & same_addr & (|(be_a & be_b));
    assign old_a     = mem[addr_a];
    assign old_b     = mem[addr_b];

    // new_x is the word that ends up at addr_x once both ports' lanes are merged,
    // so a same-address double write stores one consistent word from either port.
    // NOTE: always_comb uses blocking assignments with every output defaulted first,
    // which keeps this block free of latches.
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_a && be_a[i] && !(wr_b && same_addr && be_b[i] && COLLISION_WINNER != 0))
                new_a[i*8 +: 8] = data_a[i*8 +: 8];
            else if (wr_b && same_addr && be_b[i])
                new_a[i*8 +: 8] = data_b[i*8 +: 8];

            if (wr_b && be_b[i] && !(wr_a && same_addr && be_a[i] && COLLISION_WINNER == 0))
                new_b[i*8 +: 8] = data_b[i*8 +: 8];
            else if (wr_a && same_addr && be_a[i])
                new_b[i*8 +: 8] = data_a[i*8 +: 8];
        end
    end

    // NOTE: the array has no reset branch so it maps onto block RAM; zeroing is done
    // one word per cycle by the CLEAR state instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (busy) begin
                mem[cnt] <= '0;
            end else begin
                if (wr_a) mem[addr_a] <= new_a;
                if (wr_b) mem[addr_b] <= new_b;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1_a      <= '0;
            q1_b      <= '0;
            rv1_a     <= 1'b0;
            rv1_b     <= 1'b0;
            collision <= 1'b0;
        end else begin
            rv1_a     <= en_a & ~busy;
            rv1_b     <= en_b & ~busy;
            collision <= overlap;
            if (en_a && !busy) q1_a <= (RDW_MODE != 0 && wr_a) ? new_a : old_a;
            if (en_b && !busy) q1_b <= (RDW_MODE != 0 && wr_b) ? new_b : old_b;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_a      <= '0;
            q_b      <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            q_a      <= q1_a;
            q_b      <= q1_b;
            rvalid_a <= rv1_a;
            rvalid_b <= rv1_b;
        end
    end
`else
    assign q_a      = q1_a;
    assign q_b      = q1_b;
    assign rvalid_a = rv1_a;
    assign rvalid_b = rv1_b;
`endif

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Testbench for dual_port_ram_param: an 8-bit/64-word read-first A-wins instance and a
// 16-bit/16-word write-first B-wins instance, checked against an array-based model.
module tb_dual_port_ram_param;

`ifdef DPRAM_OUT_REG_EN
    localparam bit OUT_REG = 1'b1;
`else
    localparam bit OUT_REG = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // Stimulus indexed [instance][port], port 0 = A, 1 = B.
    logic        en   [2][2];
    logic        we   [2][2];
    logic [1:0]  be   [2][2];
    logic [5:0]  addr [2][2];
    logic [15:0] data [2][2];

    logic [7:0]  q0_a, q0_b;
    logic [15:0] q1_a, q1_b;
    logic        rv0_a, rv0_b, rv1_a, rv1_b;
    logic        busy0, busy1, col0, col1;

    int checks   = 0;
    int failures = 0;

    dual_port_ram_param #(
        .DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .COLLISION_WINNER(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en[0][0]), .we_a(we[0][0]), .be_a(be[0][0][0:0]), .addr_a(addr[0][0]),
        .data_a(data[0][0][7:0]), .q_a(q0_a), .rvalid_a(rv0_a),
        .en_b(en[0][1]), .we_b(we[0][1]), .be_b(be[0][1][0:0]), .addr_b(addr[0][1]),
        .data_b(data[0][1][7:0]), .q_b(q0_b), .rvalid_b(rv0_b),
        .busy(busy0), .collision(col0)
    );

    dual_port_ram_param #(
        .DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .COLLISION_WINNER(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en[1][0]), .we_a(we[1][0]), .be_a(be[1][0]), .addr_a(addr[1][0][3:0]),
        .data_a(data[1][0]), .q_a(q1_a), .rvalid_a(rv1_a),
        .en_b(en[1][1]), .we_b(we[1][1]), .be_b(be[1][1]), .addr_b(addr[1][1][3:0]),
        .data_b(data[1][1]), .q_b(q1_b), .rvalid_b(rv1_b),
        .busy(busy1), .collision(col1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [15:0] mmem  [2][64];
    bit          mbusy [2];
    int          left  [2];
    bit          mcol  [2];
    logic [15:0] mq1   [2][2];
    bit          mrv1  [2][2];
    logic [15:0] mq2   [2][2];
    bit          mrv2  [2][2];

    function automatic int lanes(input int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic int depth(input int k);
        return (k == 0) ? 64 : 16;
    endfunction
    function automatic bit write_first(input int k);
        return k == 1;
    endfunction
    function automatic int winner(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] prev_q  [2];
            bit          prev_rv [2];
            for (int p = 0; p < 2; p++) begin
                prev_q[p]  = mq1[k][p];
                prev_rv[p] = mrv1[k][p];
            end
            if (!rst_n) begin
                mbusy[k] = 1'b1;
                left[k]  = depth(k);
                mcol[k]  = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    mq1[k][p]  = '0;
                    mrv1[k][p] = 1'b0;
                end
            end else if (mbusy[k]) begin
                mcol[k] = 1'b0;
                for (int p = 0; p < 2; p++) mrv1[k][p] = 1'b0;
                left[k]--;
                if (left[k] == 0) begin
                    mbusy[k] = 1'b0;
                    for (int a = 0; a < 64; a++) mmem[k][a] = '0;
                end
            end else begin
                logic [15:0] oldw [2];
                bit          wr   [2];
                bit          lane_clash;
                for (int p = 0; p < 2; p++) begin
                    oldw[p] = mmem[k][addr[k][p]];
                    wr[p]   = en[k][p] && we[k][p];
                end
                lane_clash = 1'b0;
                for (int l = 0; l < lanes(k); l++)
                    if (be[k][0][l] && be[k][1][l]) lane_clash = 1'b1;
                mcol[k] = wr[0] && wr[1] && (addr[k][0] == addr[k][1]) && lane_clash;
                // Losing port writes first, winner overwrites.
                for (int o = 0; o < 2; o++) begin
                    int p;
                    p = (winner(k) == 0) ? 1 - o : o;
                    if (wr[p])
                        for (int l = 0; l < lanes(k); l++)
                            if (be[k][p][l]) mmem[k][addr[k][p]][l*8 +: 8] = data[k][p][l*8 +: 8];
                end
                for (int p = 0; p < 2; p++) begin
                    mrv1[k][p] = en[k][p];
                    if (en[k][p])
                        mq1[k][p] = (write_first(k) && wr[p]) ? mmem[k][addr[k][p]] : oldw[p];
                end
            end
            for (int p = 0; p < 2; p++) begin
                mq2[k][p]  = rst_n ? prev_q[p]  : 16'h0000;
                mrv2[k][p] = rst_n ? prev_rv[p] : 1'b0;
            end
        end
    endtask

    function automatic logic [15:0] exp_q(input int k, input int p);
        return OUT_REG ? mq2[k][p] : mq1[k][p];
    endfunction
    function automatic bit exp_rv(input int k, input int p);
        return OUT_REG ? mrv2[k][p] : mrv1[k][p];
    endfunction

    task automatic compare_all();
        check_bit("i0_busy", busy0, mbusy[0]);
        check_bit("i1_busy", busy1, mbusy[1]);
        check_bit("i0_collision", col0, mcol[0]);
        check_bit("i1_collision", col1, mcol[1]);
        check_bit("i0_rvalid_a", rv0_a, exp_rv(0, 0));
        check_bit("i0_rvalid_b", rv0_b, exp_rv(0, 1));
        check_bit("i1_rvalid_a", rv1_a, exp_rv(1, 0));
        check_bit("i1_rvalid_b", rv1_b, exp_rv(1, 1));
        check("i0_q_a", {8'h00, q0_a}, exp_q(0, 0));
        check("i0_q_b", {8'h00, q0_b}, exp_q(0, 1));
        check("i1_q_a", q1_a, exp_q(1, 0));
        check("i1_q_b", q1_b, exp_q(1, 1));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                en[k][p] = 1'b0;
                we[k][p] = 1'b0;
                be[k][p] = 2'b00;
            end
    endtask

    task automatic drive(input int k, input int p, input logic w, input logic [1:0] b,
                         input logic [5:0] a, input logic [15:0] d);
        en[k][p]   = 1'b1;
        we[k][p]   = w;
        be[k][p]   = b;
        addr[k][p] = a;
        data[k][p] = d;
    endtask

    initial begin
        int n0;
        int n1;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) mmem[k][a] = '0;
            for (int p = 0; p < 2; p++) begin
                addr[k][p] = '0;
                data[k][p] = '0;
            end
        end
        idle_all();

        // Power-up reset and initial clear.
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) step();

        // Clear after reset: preload mem[5], reset, measure busy, read back zero.
        drive(0, 0, 1'b1, 2'b01, 6'd5, 16'h00A5);
        step();
        idle_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n0 = busy0 ? 1 : 0;
        n1 = busy1 ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy0) n0++;
            if (busy1) n1++;
            if (!busy0) break;
        end
        check("i0_busy_cycles", 16'(n0), 16'd64);
        check("i1_busy_cycles", 16'(n1), 16'd16);
        drive(0, 0, 1'b0, 2'b00, 6'd5, 16'h0000);
        step();
        check_bit("i0_clear_rvalid", rv0_a, !OUT_REG);
        idle_all();
        step();
        check("i0_clear_addr5", {8'h00, q0_a}, 16'h0000);
        check_bit("i0_clear_rvalid_held", rv0_a, OUT_REG);

        // Basic dual write/read.
        drive(0, 0, 1'b1, 2'b01, 6'd1, 16'h0033);
        drive(0, 1, 1'b1, 2'b01, 6'd2, 16'h0044);
        step();
        drive(0, 0, 1'b0, 2'b00, 6'd2, 16'h0000);
        drive(0, 1, 1'b0, 2'b00, 6'd1, 16'h0000);
        step();
        idle_all();
        step();
        check("basic_q_a", {8'h00, q0_a}, 16'h0044);
        check("basic_q_b", {8'h00, q0_b}, 16'h0033);

        // Byte enables on the 16-bit instance.
        drive(1, 0, 1'b1, 2'b11, 6'd3, 16'h1234);
        step();
        drive(1, 0, 1'b1, 2'b01, 6'd3, 16'hABCD);
        step();
        drive(1, 0, 1'b0, 2'b00, 6'd3, 16'h0000);
        step();
        idle_all();
        step();
        check("byte_enable_merge", q1_a, 16'h12CD);

        // Read-during-write, both RDW modes side by side.
        drive(0, 0, 1'b1, 2'b01, 6'd4, 16'h0011);
        drive(1, 0, 1'b1, 2'b11, 6'd4, 16'h0011);
        step();
        drive(0, 0, 1'b1, 2'b01, 6'd4, 16'h0022);
        drive(0, 1, 1'b0, 2'b00, 6'd4, 16'h0000);
        drive(1, 0, 1'b1, 2'b11, 6'd4, 16'h0022);
        drive(1, 1, 1'b0, 2'b00, 6'd4, 16'h0000);
        step();
        idle_all();
        step();
        check("rdw0_q_a", {8'h00, q0_a}, 16'h0011);
        check("rdw0_q_b", {8'h00, q0_b}, 16'h0011);
        check("rdw1_q_a", q1_a, 16'h0022);
        check("rdw1_q_b", q1_b, 16'h0011);
        drive(0, 0, 1'b0, 2'b00, 6'd4, 16'h0000);
        drive(1, 0, 1'b0, 2'b00, 6'd4, 16'h0000);
        step();
        idle_all();
        step();
        check("rdw0_after", {8'h00, q0_a}, 16'h0022);
        check("rdw1_after", q1_a, 16'h0022);

        // Same-address collision: instance 0 A wins, instance 1 B wins.
        for (int k = 0; k < 2; k++) begin
            drive(k, 0, 1'b1, 2'b11, 6'd7, 16'h0055);
            drive(k, 1, 1'b1, 2'b11, 6'd7, 16'h0077);
        end
        step();
        check_bit("collision0_pulse", col0, 1'b1);
        check_bit("collision1_pulse", col1, 1'b1);
        idle_all();
        step();
        check_bit("collision0_drop", col0, 1'b0);
        check_bit("collision1_drop", col1, 1'b0);
        drive(0, 0, 1'b0, 2'b00, 6'd7, 16'h0000);
        drive(1, 0, 1'b0, 2'b00, 6'd7, 16'h0000);
        step();
        idle_all();
        step();
        check("collision0_word", {8'h00, q0_a}, 16'h0055);
        check("collision1_word", q1_a, 16'h0077);

        // Reset mid-clear with a write attempted while busy.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) drive(0, 0, 1'b1, 2'b01, 6'd9, 16'h00EE);
            step();
            idle_all();
        end
        check_bit("busy_write_rvalid", rv0_a, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n0 = busy0 ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy0) n0++;
            if (!busy0) break;
        end
        check("restart_busy_cycles", 16'(n0), 16'd64);
        drive(0, 0, 1'b0, 2'b00, 6'd9, 16'h0000);
        step();
        idle_all();
        step();
        check("busy_write_dropped", {8'h00, q0_a}, 16'h0000);

        // Randomised traffic on a narrow address window to provoke collisions.
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    en[k][p]   = ($urandom_range(0, 3) != 0);
                    we[k][p]   = ($urandom_range(0, 1) != 0);
                    be[k][p]   = 2'($urandom_range(0, 3));
                    addr[k][p] = (i < 250) ? 6'($urandom_range(0, 7))
                                           : 6'($urandom_range(0, depth(k) - 1));
                    data[k][p] = 16'($urandom);
                end
            step();
        end
        idle_all();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
